// File: rtl/spi_ram_pkg.sv
// Shared types and defaults for the SPI/host RAM arbiter.
package spi_ram_pkg;

    localparam int unsigned DEF_ADDR_SIZE = 8;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned CMD_W         = 2;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SPI_ACC  = 2'b01,
        HOST_ACC = 2'b10
    } arb_state_e;

    // One-deep SPI memory request captured from a 01/11 command.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last winner is only updated when both request.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_c  = 2'b00;
        last_d = last_q;
        if (en) begin
            case (req)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11: begin
                    gnt_c  = last_q ? 2'b01 : 2'b10;
                    last_d = ~last_q;
                end
                default: gnt_c = 2'b00;
            endcase
        end
    end

    // Index 1 (host) is the winner out of reset so index 0 wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI commands and shares a single-port RAM between SPI and a host port.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [7:0]           host_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 spi_ovf
);

    localparam logic [ADDR_SIZE-1:0] ADDR_MASK = ADDR_SIZE'(MEM_DEPTH - 1);

    logic              rx_valid_q;
    logic              rx_rise;
    cmd_e              rx_cmd;
    logic [DATA_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] rd_addr_q, rd_addr_d;
    logic              pend_q, pend_d;
    spi_req_t          req_q, req_d;
    logic              ovf_q, ovf_d;
    logic              ready_q;
    arb_state_e        state_q, state_d;
    logic              rd_q, rd_d;
    logic [7:0]        tx_hold_q, host_hold_q;
    logic [1:0]        gnt;

    assign rx_rise = rx_valid && !rx_valid_q;
    assign rx_cmd  = cmd_e'(rx_data[9:8]);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ready_q),
        .req   ({host_req, pend_q}),
        .gnt_c (gnt)
    );

    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        pend_d    = pend_q;
        req_d     = req_q;
        ovf_d     = ovf_q;
        state_d   = IDLE;
        rd_d      = 1'b0;
        host_gnt  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (gnt[0]) begin
            state_d   = SPI_ACC;
            mem_en    = 1'b1;
            mem_we    = req_q.we;
            mem_addr  = ADDR_SIZE'(req_q.addr) & ADDR_MASK;
            mem_wdata = req_q.data;
            rd_d      = !req_q.we;
            pend_d    = 1'b0;
        end else if (gnt[1]) begin
            state_d   = HOST_ACC;
            host_gnt  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr & ADDR_MASK;
            mem_wdata = host_wdata;
            rd_d      = !host_we;
        end

        // A data command that finds the slot occupied is dropped, even if the slot issues now.
        if (rx_rise) begin
            unique case (rx_cmd)
                CMD_WR_ADDR: wr_addr_d = rx_data[7:0];
                CMD_RD_ADDR: rd_addr_d = rx_data[7:0];
                CMD_WR_DATA, CMD_RD_DATA: begin
                    if (pend_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d     = 1'b1;
                        req_d.we   = (rx_cmd == CMD_WR_DATA);
                        req_d.addr = (rx_cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
                        req_d.data = rx_data[7:0];
                    end
                end
                default: ovf_d = ovf_q;
            endcase
        end
    end

    // Read data arrives one cycle after issue and is steered by the registered owner.
    assign tx_valid    = rd_q && (state_q == SPI_ACC);
    assign host_rvalid = rd_q && (state_q == HOST_ACC);
    assign tx_data     = tx_valid ? mem_rdata : tx_hold_q;
    assign host_rdata  = host_rvalid ? mem_rdata : host_hold_q;
    assign spi_ovf     = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            req_q       <= '0;
            ovf_q       <= 1'b0;
            ready_q     <= 1'b0;
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            tx_hold_q   <= '0;
            host_hold_q <= '0;
        end else begin
            rx_valid_q  <= rx_valid;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            pend_q      <= pend_d;
            req_q       <= req_d;
            ovf_q       <= ovf_d;
            ready_q     <= 1'b1;
            state_q     <= state_d;
            rd_q        <= rd_d;
            tx_hold_q   <= tx_data;
            host_hold_q <= host_rdata;
        end
    end

endmodule
